// File: rtl/semafor_pkg.sv
// Shared constants for the semafor phase scheduler: state encodings,
// the lamp selector codes understood by semafor.Sel_in, and a small
// helper used to size the phase timer.
package semafor_pkg;

    // Scheduler state encodings (also exported on the phase debug port)
    localparam logic [2:0] ST_ALLRED_A = 3'd0;
    localparam logic [2:0] ST_GREEN_A  = 3'd1;
    localparam logic [2:0] ST_AMBER_A  = 3'd2;
    localparam logic [2:0] ST_ALLRED_B = 3'd3;
    localparam logic [2:0] ST_GREEN_B  = 3'd4;
    localparam logic [2:0] ST_AMBER_B  = 3'd5;
    localparam logic [2:0] ST_NIGHT    = 3'd6;

    // Selector codes decoded by semafor into lamp patterns
    localparam logic [1:0] SEL_ALLRED = 2'b00;
    localparam logic [1:0] SEL_A      = 2'b01;
    localparam logic [1:0] SEL_B      = 2'b10;
    localparam logic [1:0] SEL_AMBER  = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/semafor_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clock cycles.
// The synchronous clear restarts the count so that a phase always
// begins with a full tick period.
module semafor_tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Count 0..CLK_DIV-1, wrapping on the tick and restarting on clear
    always_ff @(posedge clk) begin
        if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/semafor_ctrl.sv
// Phase scheduler for the two-approach traffic light. Runs the fixed
// green -> amber -> all-red sequence, times phases in prescaled ticks and
// hands right-of-way between approaches A and B based on latched demand.
// Optional night flashing mode is compiled in with SEMAFOR_NIGHT_EN.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int CLK_DIV     = 50_000_000,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_AMBER     = 3,
    parameter int T_ALLRED    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_a,
    input  logic       req_b,
`ifdef SEMAFOR_NIGHT_EN
    input  logic       night,
`endif
    output logic [1:0] sel_out,
    output logic [2:0] phase,
    output logic       pend_a,
    output logic       pend_b
);

    // The timer saturates at the longest phase length; for every legal
    // parameter set this is T_MAX_GREEN as far as green decisions go,
    // but it also keeps amber/all-red counts intact if they are longer.
    localparam int            TIMER_MAX = max3(T_MAX_GREEN, T_AMBER, T_ALLRED);
    localparam int            TW        = $clog2(TIMER_MAX + 1);
    localparam logic [TW-1:0] SAT_T     = TW'(TIMER_MAX);
    localparam logic [TW-1:0] MIN_G     = TW'(T_MIN_GREEN);
    localparam logic [TW-1:0] MAX_G     = TW'(T_MAX_GREEN);
    localparam logic [TW-1:0] AMB_T     = TW'(T_AMBER);
    localparam logic [TW-1:0] AR_T      = TW'(T_ALLRED);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] elapsed;
    logic          tick;
    logic          enter;
    logic          run;
    logic          presc_clear;
    logic          flash;
    logic          night_go;
    logic          leave_for_night;
    logic          night_req;

`ifdef SEMAFOR_NIGHT_EN
    assign night_req = night;
`else
    assign night_req = 1'b0;
`endif

    assign enter       = (state_next != state);
    assign elapsed     = (timer == SAT_T) ? timer : timer + 1'b1;
    // run holds the prescaler at zero for the release edge, so the first
    // all-red after reset lasts a full T_ALLRED ticks from that edge
    assign presc_clear = !reset_n || !run || enter;

    semafor_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Next-state selection, evaluated only on tick edges
    always_comb begin
        state_next      = state;
        leave_for_night = 1'b0;
        case (state)
            ST_ALLRED_A: begin
                if (tick && (elapsed >= AR_T)) begin
                    state_next = night_go ? ST_NIGHT : ST_GREEN_A;
                end
            end
            ST_GREEN_A: begin
                if (tick && night_req && (elapsed >= MIN_G)) begin
                    state_next      = ST_AMBER_A;
                    leave_for_night = 1'b1;
                end else if (tick && pend_b &&
                             ((!pend_a && (elapsed >= MIN_G)) || (elapsed >= MAX_G))) begin
                    state_next = ST_AMBER_A;
                end
            end
            ST_AMBER_A: begin
                if (tick && (elapsed >= AMB_T)) begin
                    state_next = ST_ALLRED_B;
                end
            end
            ST_ALLRED_B: begin
                if (tick && (elapsed >= AR_T)) begin
                    state_next = night_go ? ST_NIGHT : ST_GREEN_B;
                end
            end
            ST_GREEN_B: begin
                if (tick && night_req && (elapsed >= MIN_G)) begin
                    state_next      = ST_AMBER_B;
                    leave_for_night = 1'b1;
                end else if (tick && pend_a &&
                             ((!pend_b && (elapsed >= MIN_G)) || (elapsed >= MAX_G))) begin
                    state_next = ST_AMBER_B;
                end
            end
            ST_AMBER_B: begin
                if (tick && (elapsed >= AMB_T)) begin
                    state_next = ST_ALLRED_A;
                end
            end
            ST_NIGHT: begin
                if (tick && !night_req && !flash) begin
                    state_next = ST_ALLRED_A;
                end
            end
            default: state_next = ST_ALLRED_A;
        endcase
    end

    // State register, phase timer, night routing flag and flash phase
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_ALLRED_A;
            run      <= 1'b0;
            timer    <= '0;
            flash    <= 1'b0;
            night_go <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_next;
            if (enter) begin
                timer <= '0;
            end else if (tick) begin
                timer <= elapsed;
            end
            if (leave_for_night) begin
                night_go <= 1'b1;
            end else if (state_next == ST_NIGHT) begin
                night_go <= 1'b0;
            end
            if (enter) begin
                flash <= 1'b1;
            end else if (tick) begin
                flash <= ~flash;
            end
        end
    end

    // Demand latch for A: cleared when A gets green (same-cycle request
    // absorbed) and when night mode hands back to normal operation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_a <= 1'b0;
        end else if (enter && (state_next == ST_GREEN_A)) begin
            pend_a <= 1'b0;
        end else if (enter && (state == ST_NIGHT)) begin
            pend_a <= 1'b0;
        end else if (req_a) begin
            pend_a <= 1'b1;
        end
    end

    // Demand latch for B, mirror of the A latch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_b <= 1'b0;
        end else if (enter && (state_next == ST_GREEN_B)) begin
            pend_b <= 1'b0;
        end else if (enter && (state == ST_NIGHT)) begin
            pend_b <= 1'b0;
        end else if (req_b) begin
            pend_b <= 1'b1;
        end
    end

    // Selector decode straight from the state register, no output stage
    always_comb begin
        sel_out = SEL_ALLRED;
        case (state)
            ST_GREEN_A:             sel_out = SEL_A;
            ST_GREEN_B:             sel_out = SEL_B;
            ST_AMBER_A, ST_AMBER_B: sel_out = SEL_AMBER;
            ST_NIGHT:               sel_out = flash ? SEL_AMBER : SEL_ALLRED;
            default:                sel_out = SEL_ALLRED;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Directed bench for semafor_ctrl with CLK_DIV=4, T_MIN_GREEN=3,
// T_MAX_GREEN=6, T_AMBER=2, T_ALLRED=1. Night scenario is included
// when SEMAFOR_NIGHT_EN is defined.
module tb_semafor_ctrl;

    logic       clk;
    logic       reset_n;
    logic       req_a;
    logic       req_b;
`ifdef SEMAFOR_NIGHT_EN
    logic       night;
`endif
    logic [1:0] sel_out;
    logic [2:0] phase;
    logic       pend_a;
    logic       pend_b;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;
    int p;

    semafor_ctrl #(
        .CLK_DIV     (4),
        .T_MIN_GREEN (3),
        .T_MAX_GREEN (6),
        .T_AMBER     (2),
        .T_ALLRED    (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_a   (req_a),
        .req_b   (req_b),
`ifdef SEMAFOR_NIGHT_EN
        .night   (night),
`endif
        .sel_out (sel_out),
        .phase   (phase),
        .pend_a  (pend_a),
        .pend_b  (pend_b)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ra, input logic rb);
        req_a = ra;
        req_b = rb;
    endtask

    task automatic runTo(input int target);
        while (p < target) begin
            @(negedge clk);
            p++;
        end
    endtask

    // Reset, release, and stop at the negedge right after GREEN_A entry
    task automatic resetToGreen();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        p = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] e_sel,
                               input logic [2:0] e_phase, input logic e_pa,
                               input logic e_pb);
        logic [6:0] got;
        logic [6:0] want;
        got  = {sel_out, phase, pend_a, pend_b};
        want = {e_sel, e_phase, e_pa, e_pb};
        total_cnt++;
        assert (got === want) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: got sel=%b phase=%0d pend_a=%b pend_b=%b, expected sel=%b phase=%0d pend_a=%b pend_b=%b",
                   tag, sel_out, phase, pend_a, pend_b, e_sel, e_phase, e_pa, e_pb);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        p         = 0;
        reset_n   = 1'b0;
        applyStimulus(1'b0, 1'b0);
`ifdef SEMAFOR_NIGHT_EN
        night = 1'b0;
`endif

        // Scenario 1: reset state, 4 cycles of all-red, then A green rests
        $display("[TB] scenario 1: reset release, no demand");
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 2'b00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("first_allred", 2'b00, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("first_green_a", 2'b01, 3'd1, 1'b0, 1'b0);
        repeat (104) @(negedge clk);
        checkOutput("green_a_rests", 2'b01, 3'd1, 1'b0, 1'b0);

        // Scenario 2: one-cycle req_b pulse early in GREEN_A
        $display("[TB] scenario 2: req_b pulse");
        resetToGreen();
        runTo(1);
        applyStimulus(1'b0, 1'b1);
        runTo(2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pend_b_latched", 2'b01, 3'd1, 1'b0, 1'b1);
        runTo(11);
        checkOutput("green_a_last", 2'b01, 3'd1, 1'b0, 1'b1);
        runTo(12);
        checkOutput("amber_a_entry", 2'b11, 3'd2, 1'b0, 1'b1);
        runTo(19);
        checkOutput("amber_a_last", 2'b11, 3'd2, 1'b0, 1'b1);
        runTo(20);
        checkOutput("allred_b_entry", 2'b00, 3'd3, 1'b0, 1'b1);
        runTo(23);
        checkOutput("allred_b_last", 2'b00, 3'd3, 1'b0, 1'b1);
        runTo(24);
        checkOutput("green_b_entry", 2'b10, 3'd4, 1'b0, 1'b0);

        // Scenario 3: both requests held, max-green alternation
        $display("[TB] scenario 3: both requests held");
        resetToGreen();
        applyStimulus(1'b1, 1'b1);
        runTo(1);
        checkOutput("both_pending", 2'b01, 3'd1, 1'b1, 1'b1);
        runTo(23);
        checkOutput("maxgreen_a_last", 2'b01, 3'd1, 1'b1, 1'b1);
        runTo(24);
        checkOutput("maxgreen_a_exit", 2'b11, 3'd2, 1'b1, 1'b1);
        runTo(36);
        checkOutput("green_b_absorb", 2'b10, 3'd4, 1'b1, 1'b0);
        runTo(37);
        checkOutput("pend_b_relatch", 2'b10, 3'd4, 1'b1, 1'b1);
        runTo(59);
        checkOutput("maxgreen_b_last", 2'b10, 3'd4, 1'b1, 1'b1);
        runTo(60);
        checkOutput("maxgreen_b_exit", 2'b11, 3'd5, 1'b1, 1'b1);
        runTo(72);
        checkOutput("green_a_again", 2'b01, 3'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);

        // Scenario 4: one-cycle reset during AMBER_A
        $display("[TB] scenario 4: reset during amber");
        runTo(84);
        checkOutput("amber_before_rst", 2'b11, 3'd2, 1'b0, 1'b1);
        runTo(85);
        reset_n = 1'b0;
        runTo(86);
        checkOutput("reset_from_amber", 2'b00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        runTo(90);
        checkOutput("allred_after_rst", 2'b00, 3'd0, 1'b0, 1'b0);
        runTo(91);
        checkOutput("green_after_rst", 2'b01, 3'd1, 1'b0, 1'b0);

        // Scenario 5: req_b on the GREEN_B entry edge is absorbed
        $display("[TB] scenario 5: request on green entry");
        p = 0;
        runTo(1);
        applyStimulus(1'b0, 1'b1);
        runTo(2);
        applyStimulus(1'b0, 1'b0);
        runTo(23);
        checkOutput("pre_green_b", 2'b00, 3'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        runTo(24);
        applyStimulus(1'b0, 1'b0);
        checkOutput("entry_req_absorbed", 2'b10, 3'd4, 1'b0, 1'b0);
        runTo(124);
        checkOutput("green_b_rests", 2'b10, 3'd4, 1'b0, 1'b0);

`ifdef SEMAFOR_NIGHT_EN
        // Scenario 6: night flashing entry and exit
        $display("[TB] scenario 6: night mode");
        resetToGreen();
        night = 1'b1;
        runTo(11);
        checkOutput("night_green_hold", 2'b01, 3'd1, 1'b0, 1'b0);
        runTo(12);
        checkOutput("night_amber", 2'b11, 3'd2, 1'b0, 1'b0);
        runTo(20);
        checkOutput("night_allred", 2'b00, 3'd3, 1'b0, 1'b0);
        runTo(24);
        checkOutput("night_flash_on", 2'b11, 3'd6, 1'b0, 1'b0);
        runTo(27);
        checkOutput("night_flash_on_end", 2'b11, 3'd6, 1'b0, 1'b0);
        runTo(28);
        checkOutput("night_flash_off", 2'b00, 3'd6, 1'b0, 1'b0);
        runTo(32);
        checkOutput("night_flash_on2", 2'b11, 3'd6, 1'b0, 1'b0);
        runTo(33);
        night = 1'b0;
        runTo(36);
        checkOutput("night_wait_off", 2'b00, 3'd6, 1'b0, 1'b0);
        runTo(40);
        checkOutput("night_exit", 2'b00, 3'd0, 1'b0, 1'b0);
        runTo(44);
        checkOutput("night_green_a", 2'b01, 3'd1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
